// File: rtl/bsg_manycore_link_sram_responder_pkg.sv
// Shared types for the manycore SRAM responder: packet op codes, return types, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package bsg_manycore_link_sram_responder_pkg;

    localparam int reg_id_width_gp = 5;

    typedef enum logic [2:0] {
        e_remote_load    = 3'd0,
        e_remote_store   = 3'd1,
        e_remote_amoswap = 3'd2,
        e_remote_amoadd  = 3'd3,
        e_remote_amoor   = 3'd4,
        e_remote_amoand  = 3'd5
    } bsg_manycore_packet_op_e;

    typedef enum logic [1:0] {
        e_return_credit = 2'd0,
        e_return_int_wb = 2'd1
    } bsg_manycore_return_packet_type_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCESS = 3'd1,
        WAIT   = 3'd2,
        MODIFY = 3'd3,
        RESP   = 3'd4
    } bsg_manycore_responder_state_e;

    // True for the four atomic ops the responder can serve when AMO support is built in.
    function automatic logic is_amo(input logic [2:0] op);
        return (op == e_remote_amoswap) || (op == e_remote_amoadd) ||
               (op == e_remote_amoor)   || (op == e_remote_amoand);
    endfunction

endpackage

// File: rtl/bsg_manycore_link_sram_responder_if.sv
// Link bundle between the mesh edge and the responder: forward request in, reverse response out.
// Latency: n/a (wires only).
// Backpressure: fwd_v/fwd_ready and rev_v/rev_ready are valid-ready pairs; fwd_out_v and rev_in_* are the unused directions.
interface bsg_manycore_link_sram_responder_if
#(
    parameter int addr_width_p   = 16,
    parameter int data_width_p   = 32,
    parameter int x_cord_width_p = 4,
    parameter int y_cord_width_p = 4
);
    import bsg_manycore_link_sram_responder_pkg::*;

    // forward request into the responder
    logic                        fwd_v;
    logic                        fwd_ready;
    logic [2:0]                  fwd_op;
    logic [addr_width_p-1:0]     fwd_addr;
    logic [data_width_p-1:0]     fwd_data;
    logic [data_width_p/8-1:0]   fwd_mask;
    logic [reg_id_width_gp-1:0]  fwd_reg_id;
    logic [x_cord_width_p-1:0]   fwd_src_x;
    logic [y_cord_width_p-1:0]   fwd_src_y;
    // forward traffic out of the responder (never issued)
    logic                        fwd_out_v;
    // reverse response out of the responder
    logic                        rev_v;
    logic                        rev_ready;
    logic [1:0]                  rev_pkt_type;
    logic [data_width_p-1:0]     rev_data;
    logic [reg_id_width_gp-1:0]  rev_reg_id;
    logic [x_cord_width_p-1:0]   rev_dest_x;
    logic [y_cord_width_p-1:0]   rev_dest_y;
    logic [x_cord_width_p-1:0]   rev_src_x;
    logic [y_cord_width_p-1:0]   rev_src_y;
    // reverse traffic into the responder (dropped)
    logic                        rev_in_v;
    logic                        rev_in_ready;

    modport master (
        output fwd_v, fwd_op, fwd_addr, fwd_data, fwd_mask, fwd_reg_id, fwd_src_x, fwd_src_y,
        input  fwd_ready, fwd_out_v,
        input  rev_v, rev_pkt_type, rev_data, rev_reg_id, rev_dest_x, rev_dest_y, rev_src_x, rev_src_y,
        output rev_ready, rev_in_v,
        input  rev_in_ready
    );

    modport slave (
        input  fwd_v, fwd_op, fwd_addr, fwd_data, fwd_mask, fwd_reg_id, fwd_src_x, fwd_src_y,
        output fwd_ready, fwd_out_v,
        output rev_v, rev_pkt_type, rev_data, rev_reg_id, rev_dest_x, rev_dest_y, rev_src_x, rev_src_y,
        input  rev_ready, rev_in_v,
        output rev_in_ready
    );

endinterface

// File: rtl/bsg_manycore_link_sram_responder_amo_alu.sv
// Atomic-op combiner: new = f(old, operand, op) for swap/add/or/and; exists only with BSG_MANYCORE_RESPONDER_AMO_EN.
// Latency: combinational.
// Backpressure: none.
`ifdef BSG_MANYCORE_RESPONDER_AMO_EN
module bsg_manycore_responder_amo_alu
    import bsg_manycore_link_sram_responder_pkg::*;
#(
    parameter int data_width_p = 32
)
(
    input  logic [2:0]              op,
    input  logic [data_width_p-1:0] old_data,
    input  logic [data_width_p-1:0] operand,
    output logic [data_width_p-1:0] new_data
);

    // Select the read-modify-write result; non-AMO ops leave the word untouched.
    always_comb begin
        new_data = old_data;
        case (bsg_manycore_packet_op_e'(op))
            e_remote_amoswap: new_data = operand;
            e_remote_amoadd:  new_data = old_data + operand;
            e_remote_amoor:   new_data = old_data | operand;
            e_remote_amoand:  new_data = old_data & operand;
            default:          new_data = old_data;
        endcase
    end

endmodule
`endif

// File: rtl/bsg_manycore_link_sram_responder.sv
// Mesh-terminating responder: one SRAM access per remote load/store, one reverse packet per request (AMOs with BSG_MANYCORE_RESPONDER_AMO_EN).
// Latency: accept to rev_v is 3 cycles for loads, 2 for stores; one request in flight at a time.
// Backpressure: fwd_ready only in IDLE; the response is held stable in RESP until rev_ready.
module bsg_manycore_link_sram_responder
    import bsg_manycore_link_sram_responder_pkg::*;
#(
    parameter int addr_width_p     = 16,
    parameter int data_width_p     = 32,
    parameter int x_cord_width_p   = 4,
    parameter int y_cord_width_p   = 4,
    parameter int mem_addr_width_p = 10
)
(
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    bsg_manycore_link_sram_responder_if.slave link_sif,
    input  logic [x_cord_width_p-1:0]    my_x_i,
    input  logic [y_cord_width_p-1:0]    my_y_i,
    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [mem_addr_width_p-1:0]  mem_addr_o,
    output logic [data_width_p-1:0]      mem_data_o,
    output logic [data_width_p/8-1:0]    mem_mask_o,
    input  logic [data_width_p-1:0]      mem_data_i
);

    localparam int mask_width_lp = data_width_p / 8;

    bsg_manycore_responder_state_e     state_r;
    bsg_manycore_return_packet_type_e  rev_type_r;
    logic                              fwd_ready_r;
    logic                              rev_v_r;
    logic                              mem_v_r;
    logic                              mem_w_r;
    logic [mem_addr_width_p-1:0]       mem_addr_r;
    logic [data_width_p-1:0]           mem_data_r;
    logic [mask_width_lp-1:0]          mem_mask_r;
    logic                              oor_r;
    logic                              needs_read_r;
    logic [reg_id_width_gp-1:0]        reg_id_r;
    logic [x_cord_width_p-1:0]         src_x_r;
    logic [y_cord_width_p-1:0]         src_y_r;
    logic [x_cord_width_p-1:0]         my_x_r;
    logic [y_cord_width_p-1:0]         my_y_r;
    logic [data_width_p-1:0]           data_r;

    logic addr_oor;
    logic op_served;
    logic op_reads;

    // Any address bit above the SRAM range means the word does not exist here.
    assign addr_oor = |(link_sif.fwd_addr >> mem_addr_width_p);

`ifdef BSG_MANYCORE_RESPONDER_AMO_EN
    logic [2:0]              op_r;
    logic [data_width_p-1:0] amo_new;

    bsg_manycore_responder_amo_alu #(
        .data_width_p (data_width_p)
    ) amo_alu (
        .op       (op_r),
        .old_data (mem_data_i),
        .operand  (mem_data_r),
        .new_data (amo_new)
    );
`endif

    // Classify the incoming op: which ops touch memory, and which need the read-back path.
    always_comb begin
        op_served = (link_sif.fwd_op == e_remote_load) || (link_sif.fwd_op == e_remote_store);
        op_reads  = (link_sif.fwd_op == e_remote_load);
`ifdef BSG_MANYCORE_RESPONDER_AMO_EN
        op_served = op_served || is_amo(link_sif.fwd_op);
        op_reads  = op_reads  || is_amo(link_sif.fwd_op);
`endif
    end

    // Request FSM with registered SRAM strobes and a registered reverse packet.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            fwd_ready_r  <= 1'b0;
            rev_v_r      <= 1'b0;
            rev_type_r   <= e_return_credit;
            mem_v_r      <= 1'b0;
            mem_w_r      <= 1'b0;
            mem_addr_r   <= '0;
            mem_data_r   <= '0;
            mem_mask_r   <= '0;
            oor_r        <= 1'b0;
            needs_read_r <= 1'b0;
            reg_id_r     <= '0;
            src_x_r      <= '0;
            src_y_r      <= '0;
            my_x_r       <= '0;
            my_y_r       <= '0;
            data_r       <= '0;
`ifdef BSG_MANYCORE_RESPONDER_AMO_EN
            op_r         <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    fwd_ready_r <= 1'b1;
                    if (fwd_ready_r && link_sif.fwd_v) begin
                        fwd_ready_r  <= 1'b0;
                        mem_v_r      <= op_served && !addr_oor;
                        mem_w_r      <= (link_sif.fwd_op == e_remote_store);
                        mem_addr_r   <= link_sif.fwd_addr[mem_addr_width_p-1:0];
                        mem_data_r   <= link_sif.fwd_data;
                        mem_mask_r   <= link_sif.fwd_mask;
                        oor_r        <= addr_oor;
                        needs_read_r <= op_reads;
                        reg_id_r     <= link_sif.fwd_reg_id;
                        src_x_r      <= link_sif.fwd_src_x;
                        src_y_r      <= link_sif.fwd_src_y;
                        my_x_r       <= my_x_i;
                        my_y_r       <= my_y_i;
`ifdef BSG_MANYCORE_RESPONDER_AMO_EN
                        op_r         <= link_sif.fwd_op;
`endif
                        state_r      <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_v_r <= 1'b0;
                    if (needs_read_r) begin
                        state_r <= WAIT;
                    end else begin
                        // stores, dropped stores and unsupported ops all answer with a bare credit
                        data_r     <= '0;
                        rev_type_r <= e_return_credit;
                        rev_v_r    <= 1'b1;
                        state_r    <= RESP;
                    end
                end
                WAIT: begin
                    data_r <= oor_r ? '0 : mem_data_i;
`ifdef BSG_MANYCORE_RESPONDER_AMO_EN
                    if (is_amo(op_r) && !oor_r) begin
                        mem_v_r    <= 1'b1;
                        mem_w_r    <= 1'b1;
                        mem_data_r <= amo_new;
                        mem_mask_r <= '1;
                        state_r    <= MODIFY;
                    end else
`endif
                    begin
                        rev_type_r <= e_return_int_wb;
                        rev_v_r    <= 1'b1;
                        state_r    <= RESP;
                    end
                end
                MODIFY: begin
                    mem_v_r    <= 1'b0;
                    rev_type_r <= e_return_int_wb;
                    rev_v_r    <= 1'b1;
                    state_r    <= RESP;
                end
                RESP: begin
                    if (link_sif.rev_ready) begin
                        rev_v_r     <= 1'b0;
                        fwd_ready_r <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign link_sif.fwd_ready    = fwd_ready_r;
    assign link_sif.fwd_out_v    = 1'b0;
    assign link_sif.rev_in_ready = 1'b1;
    assign link_sif.rev_v        = rev_v_r;
    assign link_sif.rev_pkt_type = rev_type_r;
    assign link_sif.rev_data     = data_r;
    assign link_sif.rev_reg_id   = reg_id_r;
    assign link_sif.rev_dest_x   = src_x_r;
    assign link_sif.rev_dest_y   = src_y_r;
    assign link_sif.rev_src_x    = my_x_r;
    assign link_sif.rev_src_y    = my_y_r;

    assign mem_v_o    = mem_v_r;
    assign mem_w_o    = mem_w_r;
    assign mem_addr_o = mem_addr_r;
    assign mem_data_o = mem_data_r;
    assign mem_mask_o = mem_mask_r;

    // A terminating responder has nobody to hear from on the reverse link; traffic there is a wiring error.
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !link_sif.rev_in_v);

endmodule
